// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: datapath width, sequential PC step and the
// fetch sequencer state encoding.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_ERR  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one outstanding imem request at a time
// and holds the returned instruction in a 1-entry buffer for decode.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | one cycle after reset before the first request
// ST_REQ  | request presented while the buffer slot is free
// ST_WAIT | request granted, waiting for its response
// ST_ERR  | halted on a misaligned redirect target, left only by reset
module pc_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] pc,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign_err
);

   fetch_state_t    state, state_nxt;
   logic            kill, kill_nxt;
   logic [XLEN-1:0] pc_nxt, inst_nxt, inst_pc_nxt;
   logic            valid_nxt, err_nxt;
   logic            free;

   assign free      = !inst_valid || !stall;
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pc           <= RESET_PC;
         kill         <= 1'b0;
         inst_valid   <= 1'b0;
         inst         <= '0;
         inst_pc      <= '0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         kill         <= kill_nxt;
         inst_valid   <= valid_nxt;
         inst         <= inst_nxt;
         inst_pc      <= inst_pc_nxt;
         misalign_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      kill_nxt    = kill;
      valid_nxt   = inst_valid && stall;
      inst_nxt    = inst;
      inst_pc_nxt = inst_pc;
      err_nxt     = misalign_err;
      imem_req    = (state == ST_REQ) && free;

      if (state == ST_ERR) begin
         valid_nxt = 1'b0;
      end else if (redirect_valid) begin
         // the buffered instruction is wrong-path whatever happens next
         valid_nxt = 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
         end else begin
            pc_nxt = redirect_pc;
            unique case (state)
               ST_IDLE: state_nxt = ST_REQ;
               ST_REQ: begin
                  if (imem_req && imem_gnt) begin
                     kill_nxt  = 1'b1;
                     state_nxt = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (imem_rvalid) begin
                     kill_nxt  = 1'b0;
                     state_nxt = ST_REQ;
                  end else begin
                     kill_nxt = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end else begin
         unique case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
               if (imem_req && imem_gnt) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  state_nxt = ST_REQ;
                  if (kill) begin
                     kill_nxt = 1'b0;
                  end else begin
                     inst_nxt    = imem_rdata;
                     inst_pc_nxt = pc;
                     valid_nxt   = 1'b1;
                     pc_nxt      = pc + PC_STEP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl against a transaction-level fetch model,
// plus a second instance exercising PC wrap-around from the top of memory.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        misalign_err;

   logic        rst2_n = 1'b0;
   logic        gnt2 = 1'b1;
   logic        rvalid2 = 1'b0;
   logic [31:0] rdata2 = '0;
   logic        w_req, w_valid, w_err;
   logic [31:0] w_addr, w_pc, w_inst, w_inst_pc;

   pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .misalign_err(misalign_err));

   pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst2_n), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .stall(1'b0), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(gnt2),
      .imem_rvalid(rvalid2), .imem_rdata(rdata2), .pc(w_pc), .inst_valid(w_valid),
      .inst(w_inst), .inst_pc(w_inst_pc), .misalign_err(w_err));

   int n_cmp = 0;
   int n_bad = 0;

   // knobs (percent probabilities, max memory latency in cycles)
   int p_gnt, p_stall, p_redir, p_mis, lat_max;

   // reference model: fetch progress described as transactions
   bit          m_started, m_err, m_out, m_dead, m_valid;
   logic [31:0] m_pc, m_inst, m_inst_pc;

   // memory model
   bit          mem_pend;
   int          mem_lat;
   logic [31:0] mem_addr;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_err = 0; m_out = 0; m_dead = 0; m_valid = 0;
      m_pc = 32'h0; m_inst = '0; m_inst_pc = '0;
      mem_pend = 0; mem_lat = 0; mem_addr = '0;
   endtask

   task automatic check_regs();
      chk("pc", pc, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_inst_pc);
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; redirect_valid = 0; stall = 0; imem_gnt = 0; imem_rvalid = 0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      model_reset();
      check_regs();
   endtask

   task automatic do_cycle();
      bit          req_e, bus_req;
      logic [31:0] bus_addr;
      @(negedge clk);
      rst_n = 1;
      stall = ($urandom_range(99) < p_stall);
      redirect_valid = !redirect_valid && ($urandom_range(99) < p_redir);
      redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(99) < p_mis) redirect_pc = redirect_pc | 32'($urandom_range(1, 3));
      imem_rvalid = mem_pend && (mem_lat == 0);
      imem_rdata = imem_rvalid ? memf(mem_addr) : $urandom();
      imem_gnt = ($urandom_range(99) < p_gnt);
      #1;
      req_e = m_started && !m_err && !m_out && (!m_valid || !stall);
      chk("imem_req", {31'b0, imem_req}, {31'b0, req_e});
      chk("imem_addr", imem_addr, m_pc);
      bus_req = imem_req;
      bus_addr = imem_addr;
      @(posedge clk);
      if (imem_rvalid) mem_pend = 0;
      else if (mem_pend) mem_lat--;
      if (bus_req && imem_gnt) begin
         mem_pend = 1;
         mem_addr = bus_addr;
         mem_lat = $urandom_range(0, lat_max - 1);
      end
      if (m_valid && !stall) m_valid = 0;
      if (m_err) begin
         m_valid = 0;
      end else if (redirect_valid) begin
         m_valid = 0;
         if (redirect_pc[1:0] != 2'b00) begin
            m_err = 1;
         end else begin
            m_pc = redirect_pc;
            m_started = 1;
            if (req_e && imem_gnt) begin
               m_out = 1; m_dead = 1;
            end else if (m_out && imem_rvalid) begin
               m_out = 0; m_dead = 0;
            end else if (m_out) begin
               m_dead = 1;
            end
         end
      end else if (!m_started) begin
         m_started = 1;
      end else if (req_e && imem_gnt) begin
         m_out = 1; m_dead = 0;
      end else if (m_out && imem_rvalid) begin
         m_out = 0;
         if (m_dead) begin
            m_dead = 0;
         end else begin
            m_valid = 1;
            m_inst = memf(m_pc);
            m_inst_pc = m_pc;
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
      check_regs();
   endtask

   initial begin
      int          seen;
      bit          pend2, r2;
      logic [31:0] a2, ad2, exp_pc;

      // wrap-around instance: always granted, 1-cycle memory
      seen = 0; pend2 = 0; a2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst2_n = 1;
      for (int i = 0; i < 20 && seen < 2; i++) begin
         @(negedge clk);
         rvalid2 = pend2;
         rdata2 = memf(a2);
         #1;
         r2 = w_req;
         ad2 = w_addr;
         @(posedge clk);
         pend2 = r2;
         if (r2) a2 = ad2;
         #1;
         if (w_valid) begin
            exp_pc = (seen == 0) ? 32'hFFFF_FFFC : 32'h0000_0000;
            chk("wrap_inst_pc", w_inst_pc, exp_pc);
            chk("wrap_inst", w_inst, memf(exp_pc));
            seen++;
         end
      end
      chk("wrap_count", 32'(seen), 32'd2);

      // straight-line fetch, 1-cycle memory
      p_gnt = 100; p_stall = 0; p_redir = 0; p_mis = 0; lat_max = 1;
      do_reset();
      for (int i = 0; i < 14; i++) do_cycle();

      // stall-heavy, redirects, variable latency
      p_gnt = 70; p_stall = 40; p_redir = 8; lat_max = 3;
      for (int i = 0; i < 1500; i++) do_cycle();

      // misaligned redirect: halt, stay halted, then recover by reset
      p_mis = 100; p_redir = 20;
      for (int i = 0; i < 60; i++) do_cycle();
      p_mis = 0; p_redir = 0; p_gnt = 100; p_stall = 0; lat_max = 1;
      do_reset();
      for (int i = 0; i < 10; i++) do_cycle();

      // mixed random run with occasional misalignment and reset recovery
      p_gnt = 60; p_stall = 30; p_redir = 10; p_mis = 4; lat_max = 4;
      for (int i = 0; i < 2000; i++) begin
         do_cycle();
         if (m_err && $urandom_range(9) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer that owns the architectural PC and drives the instruction-memory request handshake. It sits between the next-PC logic and instruction memory, and holds one fetched instruction in a 1-entry output buffer for decode. Control flow reaches it only as a redirect pulse carrying the next-PC result. It handles stalls, wrong-path response kill and misaligned targets, turning the single-cycle next-PC path into a multi-cycle, memory-latency-tolerant front end.

## Interface
Clock and reset: one clock, `clk`; reset `rst_n` is synchronous and active-low.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `redirect_valid`  in  1  single-cycle pulse: branch taken, jal or jalr resolved.
- `redirect_pc`  in  32  target from next-PC logic.
- `stall`  in  1  decode cannot accept `inst` this cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; never in the same cycle as its grant; responses in order.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  32  current fetch PC, fed to next-PC logic.
- `inst_valid`  out  1  output buffer holds a valid instruction.
- `inst`  out  32  buffered instruction.
- `inst_pc`  out  32  PC of `inst`.
- `misalign_err`  out  1  level; high once halted on a misaligned redirect.

## Operation
- States: IDLE, REQ, WAIT, ERR. One internal `kill` flag.
- Reset values:
  - state IDLE, `pc` = RESET_PC.
  - `inst_valid` = 0; `inst`, `inst_pc` = 0.
  - `kill` = 0, `misalign_err` = 0, `imem_req` = 0.
- Buffer slot free: `free = !inst_valid || !stall`. A buffered instruction is consumed when `inst_valid && !stall`; `inst_valid` then clears unless it is refilled the same cycle.
- State transitions:
  - IDLE: always goes to REQ next cycle.
  - REQ: `imem_req = free`. If `imem_req && imem_gnt`, go to WAIT.
  - WAIT: `imem_req = 0`. When `imem_rvalid` arrives:
    - `kill` = 1: drop the data, clear `kill`, go to REQ.
    - otherwise: `inst <= imem_rdata`, `inst_pc <= pc`, `inst_valid <= 1`, `pc <= pc + 4` (mod 2^32, wraps), go to REQ.
  - ERR: `imem_req` = 0, `inst_valid` = 0, `misalign_err` = 1. Left only by reset.
- At most one request is outstanding, and a request is issued only while the slot is free. A response therefore never finds the buffer occupied, and no back-pressure exists on `imem_rvalid`.
- Redirect has priority over stall, over the sequential increment and over response capture:
  - Always: `inst_valid <= 0`, since the buffered instruction is wrong-path.
  - If `redirect_pc[1:0] != 0`: go to ERR; `pc` is unchanged.
  - REQ without grant: `pc <= redirect_pc`, stay in REQ. Changing the address of an ungranted request is legal.
  - REQ with grant in the same cycle: `pc <= redirect_pc`, `kill <= 1`, go to WAIT.
  - WAIT without `imem_rvalid`: `pc <= redirect_pc`, `kill <= 1`.
  - WAIT with `imem_rvalid` in the same cycle: drop the data, `pc <= redirect_pc`, `kill` stays 0, go to REQ.
  - IDLE: `pc <= redirect_pc`, go to REQ.
- Reset asserted mid-operation: next cycle is IDLE with all reset values. A response outstanding at reset is the memory's responsibility; the bench resets both together.

## Timing
- First request: cycle 1 after reset release (`imem_req` = 1, `imem_addr` = RESET_PC).
- Latency, gnt to `inst_valid`: response cycle + 1.
- Peak throughput: one instruction per 2 cycles with 1-cycle memory (REQ/gnt, then WAIT/rvalid).
- Redirect to new-target request: next cycle when in REQ. When in WAIT, the first cycle after the killed response.
- Outputs are registered except `imem_req`, which is combinational from state and `free`.

## Structure
- Shared package `cpu_pkg`:
  - state encoding localparams ST_IDLE, ST_REQ, ST_WAIT, ST_ERR (2 bits).
  - PC_STEP = 4.
  - XLEN = 32.
- Single flat module; the 1-entry buffer and `kill` flag are inline. No sub-module is warranted.

## Test plan
- Straight-line fetch: reset, 1-cycle memory, no stall → `inst_pc` = 0, 4, 8 in consecutive `inst_valid` cycles spaced 2 cycles apart. Each `inst` equals the memory word at that address.
- Stall: hold `stall` = 1 while `inst_valid` = 1 at `inst_pc` = 8 → `imem_req` stays 0 and `inst` is held. Release `stall` → next request at 12.
- Kill in WAIT: grant at 0x10, pulse `redirect_pc` = 0x100 before `imem_rvalid` → the 0x10 response is dropped (`inst_valid` stays 0), then `imem_addr` = 0x100.
- Redirect in REQ with grant in the same cycle:
  - redirect to 0x40 on the grant cycle of 0x20 → the 0x20 response is discarded and the next request is 0x40.
  - redirect on the `imem_rvalid` cycle → that data is discarded, `inst_valid` = 0, and the next request is at the target.
- Misaligned redirect: `redirect_pc` = 0x102 → `misalign_err` = 1 next cycle and `imem_req` stays 0 indefinitely. Reset restores fetch at RESET_PC.
- PC wrap: RESET_PC = 32'hFFFF_FFFC → first `inst_pc` = 0xFFFF_FFFC, second = 0x0000_0000.
